// File: rtl/shift_seq8.sv
// -----------------------------------------------------------------------------
// shift_seq8 -- multi-cycle 8-bit shifter built around a 2-bit shift stage.
//
// A request is taken in IDLE, then shifted by at most 3 bit positions per
// cycle in SHIFT until the whole amount is used up. The result is held in DONE
// until the consumer takes it. Op codes: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
//
// Configuration macro:
//   SHIFT_SEQ8_ROR_EN  defined   : op=11 rotates right.
//                      undefined : op=11 behaves as LSR; no rotate logic built.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous active-high reset
//   i_valid  in   1  request present
//   i_ready  out  1  block can accept a request (state IDLE)
//   d_in     in   8  operand
//   shamt    in   3  shift amount 0..7
//   op       in   2  shift operation
//   o_valid  out  1  result available (state DONE)
//   o_ready  in   1  consumer takes the result
//   d_out    out  8  result (work register)
//   co       out  1  last bit shifted/rotated out; 0 when shamt=0
//   busy     out  1  high in SHIFT or DONE
// -----------------------------------------------------------------------------
module shift_seq8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic [7:0] d_in,
  input  logic [2:0] shamt,
  input  logic [1:0] op,
  output logic       o_valid,
  input  logic       o_ready,
  output logic [7:0] d_out,
  output logic       co,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b10;
`ifdef SHIFT_SEQ8_ROR_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [7:0] work;
  logic [2:0] rem;
  logic [1:0] op_r;
  logic       co_r;

  logic [1:0] step;
  logic [2:0] fill;
  logic [7:0] shifted;
  logic       shifted_co;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = SHIFT;
      // Finished when this cycle's step consumes what is left (covers rem=0).
      SHIFT:   if (rem == {1'b0, step}) state_nxt = DONE;
      DONE:    if (o_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign busy    = (state == SHIFT) || (state == DONE);
  assign d_out   = work;
  assign co      = co_r;

  // ---------------------------------------------------------------------------
  // 2-bit-amount shift stage
  // ---------------------------------------------------------------------------
  assign step = (rem > 3'd3) ? 2'd3 : rem[1:0];

  // Bits entering at the MSB end for right shifts: zeros for LSR (and for op=11
  // when rotate is not built), sign copies for ASR, the departing low bits for
  // ROR.
  always_comb begin
    fill = 3'b000;
    if (op_r == OP_ASR) begin
      fill = {3{work[7]}};
    end
`ifdef SHIFT_SEQ8_ROR_EN
    else if (op_r == OP_ROR) begin
      fill = work[2:0];
    end
`endif
  end

  // The 9-bit concatenations pair the result with the carry: for left shifts
  // the carry is the MSB of the concatenation, for right shifts the LSB.
  // step=0 keeps both the work register and the carry unchanged.
  always_comb begin
    shifted    = work;
    shifted_co = co_r;
    if (op_r == OP_LSL) begin
      case (step)
        2'd1:    {shifted_co, shifted} = {work,      1'b0};
        2'd2:    {shifted_co, shifted} = {work[6:0], 2'b00};
        2'd3:    {shifted_co, shifted} = {work[5:0], 3'b000};
        default: ;
      endcase
    end else begin
      case (step)
        2'd1:    {shifted, shifted_co} = {fill[0],   work};
        2'd2:    {shifted, shifted_co} = {fill[1:0], work[7:1]};
        2'd3:    {shifted, shifted_co} = {fill[2:0], work[7:2]};
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work <= 8'h00;
      rem  <= 3'd0;
      op_r <= 2'b00;
      co_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            work <= d_in;
            rem  <= shamt;
            op_r <= op;
            co_r <= 1'b0;
          end
        end
        SHIFT: begin
          work <= shifted;
          co_r <= shifted_co;
          rem  <= rem - {1'b0, step};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq8.sv
// -----------------------------------------------------------------------------
// tb_shift_seq8 -- self-checking bench for shift_seq8.
//
// Directed cases for the documented operand/amount combinations, output hold
// under back-pressure, reset in the middle of a shift, then randomized single
// requests and a streaming run with o_ready tied high. Expected values come
// from a whole-word arithmetic shift model and a latency table.
// Honours SHIFT_SEQ8_ROR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_shift_seq8;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic [1:0] op;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] d_out;
  logic       co;
  logic       busy;

  int n_vectors     = 0;
  int n_miscompares = 0;

  shift_seq8 dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .d_in    (d_in),
    .shamt   (shamt),
    .op      (op),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .d_out   (d_out),
    .co      (co),
    .busy    (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole shift done in one step on a widened word; returns {co, result}.
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic [1:0] o);
    logic [15:0] w;
    logic [7:0]  r;
    logic        c;
    logic [1:0]  eff;
    eff = o;
`ifndef SHIFT_SEQ8_ROR_EN
    if (o == 2'b11) eff = 2'b01;
`endif
    case (eff)
      2'b00: begin w = {8'h00, d} << s; r = w[7:0];  c = w[8]; end
      2'b01: begin w = {d, 8'h00} >> s; r = w[15:8]; c = w[7]; end
      2'b10: begin w = $signed({d, 8'h00}) >>> s; r = w[15:8]; c = w[7]; end
      default: begin w = {d, d} >> s; r = w[7:0]; c = r[7]; end
    endcase
    if (s == 3'd0) c = 1'b0;
    return {c, r};
  endfunction

  // SHIFT occupancy in cycles for a given amount.
  function automatic int shift_cycles(input logic [2:0] s);
    if (s <= 3'd3) return 1;
    if (s <= 3'd6) return 2;
    return 3;
  endfunction

  task automatic scramble();
    d_in  = 8'($urandom);
    shamt = 3'($urandom);
    op    = 2'($urandom);
  endtask

  // One full request: accept, count SHIFT cycles, hold in DONE for 'hold'
  // cycles with garbage on the inputs, then hand the result off.
  task automatic do_req(input logic [7:0] d, input logic [2:0] s, input logic [1:0] o,
                        input int hold, input string tag, output logic [8:0] got);
    logic [8:0] exp;
    int         cnt;
    exp = ref_shift(d, s, o);
    @(negedge clk);
    check({tag, ".idle_ready"}, {busy, i_ready}, 2'b01);
    i_valid = 1'b1;
    d_in    = d;
    shamt   = s;
    op      = o;
    @(negedge clk);
    i_valid = 1'b0;
    scramble();
    check({tag, ".accepted"}, {busy, i_ready, o_valid}, 3'b100);
    cnt = 0;
    while (!o_valid && cnt < 8) begin
      @(negedge clk);
      scramble();
      cnt++;
    end
    check({tag, ".latency"}, cnt, shift_cycles(s));
    got = {co, d_out};
    check({tag, ".result"}, got, exp);
    i_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
      check({tag, ".hold"}, {o_valid, i_ready, busy, co, d_out}, {3'b101, exp});
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    // i_valid stayed high across the handshake edge: nothing may be accepted.
    check({tag, ".released"}, {o_valid, i_ready, busy}, 3'b010);
    i_valid = 1'b0;
  endtask

  // Back-to-back requests with o_ready tied high.
  task automatic stream(input int nreq);
    logic [8:0] exp_q[$];
    int         issued;
    int         done;
    int         cyc;
    int         last_acc;
    int         gap;
    logic [8:0] e;
    issued   = 0;
    done     = 0;
    cyc      = 0;
    last_acc = -1;
    gap      = 0;
    o_ready  = 1'b1;
    while (!(done == nreq && i_ready) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (o_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
        check("stream.result", {co, d_out}, e);
        done++;
      end
      if (i_ready) begin
        if (last_acc >= 0) begin
          check("stream.gap", cyc - last_acc, gap);
          last_acc = -1;
        end
        if (issued < nreq) begin
          scramble();
          i_valid = 1'b1;
          exp_q.push_back(ref_shift(d_in, shamt, op));
          gap      = shift_cycles(shamt) + 2;
          last_acc = cyc;
          issued++;
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    check("stream.finished", done, nreq);
    i_valid = 1'b0;
    o_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] got;

    reset   = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    d_in    = 8'h00;
    shamt   = 3'd0;
    op      = 2'b00;
    #2;
    check("reset.state", {o_valid, i_ready, busy, co, d_out}, {3'b010, 9'h000});
    @(negedge clk);
    reset = 1'b0;

    // Documented cases on 8'b10101101.
    do_req(8'hAD, 3'd3, 2'b10, 0, "asr3", got);
    check("asr3.value", got, {1'b1, 8'hF5});
    do_req(8'hAD, 3'd7, 2'b10, 0, "asr7", got);
    // The last bit out of an ASR by 7 is operand bit 6, which is 0 here.
    check("asr7.value", got, {1'b0, 8'hFF});
    do_req(8'hAD, 3'd7, 2'b01, 0, "lsr7", got);
    check("lsr7.value", got, {1'b0, 8'h01});
    do_req(8'hAD, 3'd5, 2'b00, 0, "lsl5", got);
    check("lsl5.value", got, {1'b1, 8'hA0});
    do_req(8'hAD, 3'd0, 2'b00, 0, "lsl0", got);
    check("lsl0.value", got, {1'b0, 8'hAD});
    do_req(8'hAD, 3'd3, 2'b11, 4, "ror3", got);
`ifdef SHIFT_SEQ8_ROR_EN
    check("ror3.value", got, {1'b1, 8'hB5});
`else
    check("ror3.value", got, {1'b1, 8'h15});
`endif

    // Reset in the middle of a 3-cycle shift.
    @(negedge clk);
    i_valid = 1'b1;
    d_in    = 8'h5A;
    shamt   = 3'd7;
    op      = 2'b00;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.async", {o_valid, i_ready, busy, co, d_out}, {3'b010, 9'h000});
    @(negedge clk);
    check("rst_mid.held", {o_valid, i_ready, busy, co, d_out}, {3'b010, 9'h000});
    reset = 1'b0;
    do_req(8'h96, 3'd6, 2'b10, 1, "after_rst", got);

    // Randomized single requests.
    for (int i = 0; i < 30; i++) begin
      do_req(8'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 2)),
             "rand", got);
    end

    stream(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
